// File: rtl/core_bus_pkg.sv
// Shared Core bus definitions: MMIO window location and offsets, program base,
// address-region enum and the region decode helper used by the memory responder.
package core_bus_pkg;

    localparam logic [23:0] MMIO_BASE   = 24'hFFFF00;
    localparam logic [1:0]  MMIO_LED    = 2'd0;
    localparam logic [1:0]  MMIO_CNT_LO = 2'd1;
    localparam logic [1:0]  MMIO_CNT_HI = 2'd2;
    localparam logic [1:0]  MMIO_STATUS = 2'd3;
    localparam logic [23:0] PROG_BASE   = 24'd16384;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_UNMAPPED
    } region_e;

    // RAM occupies the bottom 2**aw words; MMIO is a 4-word window at mmio_base.
    function automatic region_e decode_region(input logic [23:0] addr,
                                              input int unsigned aw,
                                              input logic [23:0] mmio_base);
        if ((addr >> aw) == 24'd0) begin
            return REG_RAM;
        end
        if (addr[23:2] == mmio_base[23:2]) begin
            return REG_MMIO;
        end
        return REG_UNMAPPED;
    endfunction

endpackage

// File: rtl/mem_dp_ram.sv
// Word RAM with one write port and one synchronous read port, read-first on
// same-address collision. Contents are never reset; only the read register is.
// Ports:
//   clk, rst_n         clock, async active-low reset (read register only)
//   we_i/waddr_i/wdata_i  write port
//   raddr_i            read address, sampled every edge
//   rdata_o            registered read data
module mem_dp_ram #(
    parameter int unsigned AW        = 15,
    parameter int unsigned DW        = 16,
    parameter string       INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [0:(1 << AW) - 1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Reads the array before this edge's write lands, giving read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/core_mem_responder.sv
// Memory-side responder for the Core bus. Returns read data for every address one
// cycle later, commits Core writes to RAM or the LED register, and lets a host
// loader write RAM whenever the Core is not writing RAM itself.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   core_to_mem_addr/_data/_write_enable  Core request (sampled every cycle)
//   mem_to_core_data               read data for the previous cycle's address
//   load_valid/load_ready/load_addr/load_data  loader write handshake
//   led                            MMIO LED register
module core_mem_responder #(
    parameter int unsigned AW        = 15,
    parameter logic [23:0] MMIO_BASE = core_bus_pkg::MMIO_BASE,
    parameter string       INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [23:0]   core_to_mem_addr,
    input  logic [15:0]   core_to_mem_data,
    input  logic          core_to_mem_write_enable,
    output logic [15:0]   mem_to_core_data,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [AW-1:0] load_addr,
    input  logic [15:0]   load_data,
    output logic [15:0]   led
);

    import core_bus_pkg::*;

    region_e       region;
    logic          core_ram_we;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [15:0]   ram_wdata;
    logic [15:0]   ram_rdata;
    logic [15:0]   mmio_word;

    logic [15:0]   led_q;
    logic [31:0]   cnt_q;
    logic          busy_sticky_q;
    region_e       rd_sel_q;
    logic [15:0]   mmio_rdata_q;

    assign region      = decode_region(core_to_mem_addr, AW, MMIO_BASE);
    assign core_ram_we = core_to_mem_write_enable && (region == REG_RAM);

    // Single RAM write port: the Core wins, the loader waits.
    assign load_ready = !core_ram_we;
    assign ram_we     = core_ram_we || load_valid;
    assign ram_waddr  = core_ram_we ? core_to_mem_addr[AW-1:0] : load_addr;
    assign ram_wdata  = core_ram_we ? core_to_mem_data : load_data;

    mem_dp_ram #(
        .AW        (AW),
        .DW        (16),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (core_to_mem_addr[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        mmio_word = 16'h0000;
        unique case (core_to_mem_addr[1:0])
            MMIO_LED:    mmio_word = led_q;
            MMIO_CNT_LO: mmio_word = cnt_q[15:0];
            MMIO_CNT_HI: mmio_word = cnt_q[31:16];
            MMIO_STATUS: mmio_word = {15'b0, busy_sticky_q};
            default:     mmio_word = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q         <= 16'h0000;
            cnt_q         <= 32'd0;
            busy_sticky_q <= 1'b0;
            rd_sel_q      <= REG_RAM;
            mmio_rdata_q  <= 16'h0000;
        end else begin
            cnt_q    <= cnt_q + 32'd1;
            rd_sel_q <= region;
            // Non-MMIO captures zero so unmapped reads return 0 via the same register.
            mmio_rdata_q <= (region == REG_MMIO) ? mmio_word : 16'h0000;
            if (core_to_mem_write_enable && (region == REG_MMIO)
                && (core_to_mem_addr[1:0] == MMIO_LED)) begin
                led_q <= core_to_mem_data;
            end
            if (load_valid && !load_ready) begin
                busy_sticky_q <= 1'b1;
            end
        end
    end

    // Output is a pure select between two registers, so it stays glitch-free.
    always_comb begin
        mem_to_core_data = 16'h0000;
        case (rd_sel_q)
            REG_RAM:  mem_to_core_data = ram_rdata;
            REG_MMIO: mem_to_core_data = mmio_rdata_q;
            default:  mem_to_core_data = 16'h0000;
        endcase
    end

    assign led = led_q;

endmodule

// File: tb/tb_core_mem_responder.sv
module tb_core_mem_responder;

    localparam logic [23:0] MB = 24'hFFFF00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] core_to_mem_addr = '0;
    logic [15:0] core_to_mem_data = '0;
    logic        core_to_mem_write_enable = 1'b0;
    logic [15:0] mem_to_core_data;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [14:0] load_addr = '0;
    logic [15:0] load_data = '0;
    logic [15:0] led;

    always #5 clk = ~clk;

    core_mem_responder #(
        .AW        (15),
        .MMIO_BASE (MB),
        .INIT_FILE ("")
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .core_to_mem_addr         (core_to_mem_addr),
        .core_to_mem_data         (core_to_mem_data),
        .core_to_mem_write_enable (core_to_mem_write_enable),
        .mem_to_core_data         (mem_to_core_data),
        .load_valid               (load_valid),
        .load_ready               (load_ready),
        .load_addr                (load_addr),
        .load_data                (load_data),
        .led                      (led)
    );

    typedef struct {
        bit          chk;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned edges;

    // Reference cycle count: edges seen with reset released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    function automatic void check(input string name, input logic [15:0] act,
                                  input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: each cycle's read result appears after the following edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) check(e.name, mem_to_core_data, e.exp);
        end
    end

    task automatic cyc(input logic [23:0] a, input logic [15:0] wd, input logic we,
                       input logic lv, input logic [14:0] la, input logic [15:0] ld,
                       input bit chk, input logic [15:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        core_to_mem_addr         = a;
        core_to_mem_data         = wd;
        core_to_mem_write_enable = we;
        load_valid               = lv;
        load_addr                = la;
        load_data                = ld;
        e.chk = chk; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    task automatic rd(input logic [23:0] a, input logic [15:0] exp, input string name);
        cyc(a, 16'h0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b1, exp, name);
    endtask

    task automatic wr(input logic [23:0] a, input logic [15:0] d);
        cyc(a, d, 1'b1, 1'b0, 15'h0, 16'h0, 1'b0, 16'h0, "wr");
    endtask

    task automatic rd_cnt(input bit hi, input string name);
        exp_t e;
        @(negedge clk);
        core_to_mem_addr         = hi ? MB + 24'd2 : MB + 24'd1;
        core_to_mem_write_enable = 1'b0;
        load_valid               = 1'b0;
        e.chk = 1'b1; e.name = name;
        e.exp = hi ? edges[31:16] : edges[15:0];
        sb.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset_data", mem_to_core_data, 16'h0000);
        check("reset_led", led, 16'h0000);
        check("reset_load_ready", {15'b0, load_ready}, 16'h0001);
        @(negedge clk);
        rst_n = 1'b1;

        wr(24'h004000, 16'hBEEF);
        rd(24'h004000, 16'hBEEF, "ram_beef");

        wr(24'h000010, 16'h0000);
        cyc(24'h000010, 16'h1234, 1'b1, 1'b0, 15'h0, 16'h0, 1'b1, 16'h0000, "rdw_old");
        rd(24'h000010, 16'h1234, "rdw_new");
        wr(24'h000000, 16'hCAFE);

        // Core RAM write collides with loader.
        cyc(24'h000020, 16'h5555, 1'b1, 1'b1, 15'h0021, 16'h7777, 1'b0, 16'h0, "coll");
        #1 check("lr_blocked", {15'b0, load_ready}, 16'h0000);
        cyc(MB + 24'd3, 16'h0, 1'b0, 1'b1, 15'h0021, 16'h7777, 1'b1, 16'h0001, "status_sticky");
        #1 check("lr_accept", {15'b0, load_ready}, 16'h0001);
        rd(24'h000021, 16'h7777, "load_commit");
        rd(24'h000020, 16'h5555, "core_commit");

        // MMIO write does not block the loader.
        cyc(MB, 16'h00A5, 1'b1, 1'b1, 15'h0030, 16'h3030, 1'b0, 16'h0, "led_wr");
        #1 check("lr_mmio_wr", {15'b0, load_ready}, 16'h0001);
        rd(MB, 16'h00A5, "mmio_led_rd");
        check("led_port", led, 16'h00A5);
        rd(24'h000030, 16'h3030, "load_during_mmio");
        wr(MB + 24'd1, 16'h1111);
        rd(MB, 16'h00A5, "led_keep");

        wr(24'h800000, 16'hFFFF);
        rd(24'h800000, 16'h0000, "unmapped_rd");
        rd(24'h000000, 16'hCAFE, "unmapped_no_alias");
        rd(24'hFFFEFC, 16'h0000, "near_mmio_unmapped");

        rd_cnt(1'b0, "cnt_lo");
        rd_cnt(1'b1, "cnt_hi");
        repeat (70000) @(negedge clk);
        rd_cnt(1'b0, "cnt_lo_wrap");
        rd(MB + 24'd2, 16'h0001, "cnt_hi_wrap");

        // Asynchronous reset between edges.
        rd(24'h004000, 16'hBEEF, "pre_reset");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_out", mem_to_core_data, 16'h0000);
        check("rst_led", led, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rd(MB + 24'd1, 16'h0001, "cnt_after_rst");
        rd(MB, 16'h0000, "led_after_rst");
        rd(24'h004000, 16'hBEEF, "ram_kept");

        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
